// File: rtl/aes_dec_iter.sv
// Iterative AES-128 inverse cipher: one shared round datapath, ten round cycles per block.
// The round-10 key is unrolled backwards on the fly, so no round-key storage is needed.
module aes_dec_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   fsm_r;
  logic [3:0]   round_r;
  logic [127:0] state_r;
  logic [127:0] key_r;

  logic [31:0]  w0_s, w1_s, w2_s, w3_s;
  logic [31:0]  nw0_s, nw1_s, nw2_s, nw3_s;
  logic [31:0]  sub_rot_s;
  logic [127:0] key_prev_s;
  logic [127:0] shifted_s;
  logic [127:0] subbed_s;
  logic [127:0] added_s;
  logic [127:0] mixed_s;
  logic [127:0] round_out_s;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (b[i] ? aa : 8'h00);
      aa  = xtime(aa);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 via a short square-and-multiply chain; 00 maps to 00.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x12, x15, x240, x252;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x12  = gf_mul(x3, x3);
    x12  = gf_mul(x12, x12);
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return affine(gf_inv(b));
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_inv(inv_affine(b));
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] x2, x4, x8;
    logic [7:0] m09 [4];
    logic [7:0] m0b [4];
    logic [7:0] m0d [4];
    logic [7:0] m0e [4];
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      a[i]   = col[31-8*i -: 8];
      x2     = xtime(a[i]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m09[i] = x8 ^ a[i];
      m0b[i] = x8 ^ x2 ^ a[i];
      m0d[i] = x8 ^ x4 ^ a[i];
      m0e[i] = x8 ^ x4 ^ x2;
    end
    res = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      res[31-8*i -: 8] = m0e[i] ^ m0b[(i+1)%4] ^ m0d[(i+2)%4] ^ m09[(i+3)%4];
    end
    return res;
  endfunction

  assign in_ready = (fsm_r == IDLE) & ~rst;

  // Round datapath: previous round key, then InvShiftRows/InvSubBytes/AddRoundKey/InvMixColumns.
  always_comb begin
    w0_s  = key_r[127:96];
    w1_s  = key_r[95:64];
    w2_s  = key_r[63:32];
    w3_s  = key_r[31:0];
    nw3_s = w3_s ^ w2_s;
    nw2_s = w2_s ^ w1_s;
    nw1_s = w1_s ^ w0_s;
    sub_rot_s = {sbox(nw3_s[23:16]), sbox(nw3_s[15:8]), sbox(nw3_s[7:0]), sbox(nw3_s[31:24])};
    nw0_s = w0_s ^ sub_rot_s ^ {rcon(round_r), 24'h00_0000};
    key_prev_s = {nw0_s, nw1_s, nw2_s, nw3_s};

    shifted_s = 128'h0;
    subbed_s  = 128'h0;
    mixed_s   = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted_s[127-8*(r+4*c) -: 8] = state_r[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    for (int b = 0; b < 16; b++) begin
      subbed_s[127-8*b -: 8] = inv_sbox(shifted_s[127-8*b -: 8]);
    end
    added_s = subbed_s ^ key_prev_s;
    for (int c = 0; c < 4; c++) begin
      mixed_s[127-32*c -: 32] = inv_mix_col(added_s[127-32*c -: 32]);
    end
    // The last round carries no InvMixColumns.
    if (round_r == 4'd1) begin
      round_out_s = added_s;
    end else begin
      round_out_s = mixed_s;
    end
  end

  // Control FSM, round counter and state/key/output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r     <= IDLE;
      round_r   <= 4'd0;
      state_r   <= 128'h0;
      key_r     <= 128'h0;
      plaintext <= 128'h0;
      out_valid <= 1'b0;
    end else begin
      case (fsm_r)
        IDLE: begin
          if (in_valid) begin
            state_r <= ciphertext ^ key_last;
            key_r   <= key_last;
            round_r <= 4'd10;
            fsm_r   <= BUSY;
          end
        end
        BUSY: begin
          state_r <= round_out_s;
          key_r   <= key_prev_s;
          round_r <= round_r - 4'd1;
          if (round_r == 4'd1) begin
            plaintext <= round_out_s;
            out_valid <= 1'b1;
            fsm_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fsm_r     <= IDLE;
          end
        end
        default: begin
          fsm_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_dec_iter.md
# aes_dec_iter

Iterative AES-128 inverse cipher that decrypts one 128-bit block in 10 round cycles using a single shared round datapath. The caller supplies the ciphertext and the final (round-10) round key; the block unrolls the key schedule backwards on the fly, so no key storage is needed. It sits on the decrypt side of the AES datapath, beside the encrypt round logic, and reuses the package types and composite-field S-box helpers (inv_affine, isomorph, GF(2^4) inversion, inv_isomorph).

## Interface
- No parameters. Key size is fixed at AES-128, Nr = 10.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ciphertext/key present.
- in_ready  out  1  block can accept; equals (fsm==IDLE) & !rst.
- ciphertext  in  aes_128  byte 0 = first block byte, column-major (bytes 4c..4c+3 = column c).
- key_last  in  aes_128  round-10 round key, same byte order; word i = bytes 4i..4i+3.
- out_valid  out  1  plaintext valid; registered.
- out_ready  in  1  consumer accepts plaintext.
- plaintext  out  aes_128  result; registered.

## Operation
- FSM states: IDLE, BUSY, DONE. On reset: IDLE, round counter 0, state and key registers 0, plaintext 0, out_valid 0.
- IDLE -> BUSY on in_valid & in_ready:
  - state <= ciphertext ^ key_last
  - key <= key_last
  - round <= 10
- BUSY, each edge:
  - Derive rk_(r-1) from the current key rk_r, with r = round:
    - w3' = w3^w2
    - w2' = w2^w1
    - w1' = w1^w0
    - w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon[r],00,00,00}
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - key <= rk_(r-1).
  - state <= InvShiftRows, then InvSubBytes, then AddRoundKey(rk_(r-1)), then InvMixColumns.
  - InvMixColumns is skipped when round==1, which is the final round.
  - round <= round-1.
  - When round==1: plaintext <= result, out_valid <= 1, next state DONE.
- InvShiftRows is the inverse of the package shift_rows:
  - out[1]=in[13], out[5]=in[1], out[9]=in[5], out[13]=in[9]
  - row 2 swaps bytes 2↔10 and 6↔14
  - out[3]=in[7], out[7]=in[11], out[11]=in[15], out[15]=in[3]
- InvSubBytes per byte = composite-field inverse of inv_affine(b). The inverse of 00 maps to 00. 16 instances serve the state and 4 serve SubWord; these are forward S-boxes (affine of inverse).
- InvMixColumns per column uses xtime chains: out_i = 0e·a_i ^ 0b·a_(i+1) ^ 0d·a_(i+2) ^ 09·a_(i+3), indices mod 4.
- DONE: plaintext and out_valid are held stable until out_ready. On out_valid & out_ready: out_valid <= 0, next state IDLE.
- in_valid is ignored outside IDLE. Input changes during BUSY/DONE have no effect.
- Reset at any state (mid-round included) wins over all other events: it aborts the operation and returns all registers to their reset values.

## Timing
- Accept edge k: state and key are loaded.
- Rounds complete on edges k+1..k+10. out_valid is high from edge k+10, i.e. 10 cycles after accept.
- With out_ready held high: the handshake happens on edge k+11, in_ready is high after edge k+11, and the next accept is at edge k+12 at the earliest. Peak throughput is 1 block / 12 cycles.
- The critical path is one round: InvShiftRows (wiring), S-box, key XOR, InvMixColumns. The key-path S-box is in series with the state AddRoundKey.
- in_ready is combinational from fsm and rst. out_valid and plaintext come directly from flops.

## Test plan
- FIPS-197 C.1:
  - Stimulus: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, key_last 13111d7fe3944a17f307a78b4d2b30c5.
  - Required response: plaintext 00112233445566778899aabbccddeeff, out_valid exactly 10 cycles after the accept edge.
- FIPS-197 App. B:
  - Stimulus: ciphertext 3925841d02dc09fbdc118597196a0b32, key_last d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Required response: plaintext 3243f6a8885a308d313198a2e0370734.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles after out_valid.
  - Required response: plaintext stable, out_valid high and in_ready low throughout. After the handshake, in_ready rises the next cycle. A back-to-back second vector (App. B after C.1) decrypts correctly.
- Busy isolation:
  - Stimulus: toggle in_valid and drive random ciphertext/key_last during BUSY.
  - Required response: no second accept, and C.1 result still correct.
- Reset mid-operation:
  - Stimulus: assert rst at round counter 5 for 1 cycle.
  - Required response: out_valid 0, plaintext 0, in_ready 1 the cycle after rst drops. A following C.1 vector decrypts correctly.
- Zero/random sweep:
  - Stimulus: ciphertext 0 with key_last 0, plus 1000 random pairs.
  - Required response: plaintext matches the software AES-128 inverse model, with key_last taken as the expanded round-10 key.
